// File: rtl/iq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : iq_pkg
//  Description : Shared constants and FSM state encoding for the instruction
//                fetch scheduler and the instruction queue.
//  Revision    : 1.0  initial release
// ============================================================================
package iq_pkg;

    localparam int          ISSUEWIDTH = 4;
    localparam int          BUFFERSIZE = 10;
    localparam int          TABLESIZE  = 10;
    localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

    // Fetch scheduler states; the values are visible on the debug port.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FLUSH = 2'd3
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_timeout
//  Description : Response timeout counter. load clears the count, enable
//                advances it, expire flags the final count (LIMIT-1).
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_timeout #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_enable,
    output logic o_expire
);

    localparam int               c_W    = (LIMIT > 2) ? $clog2(LIMIT) : 1;
    localparam logic [c_W-1:0]   c_LAST = c_W'(LIMIT - 1);

    logic [c_W-1:0] r_cnt;

    // Counter register: clear has priority over counting.
    always_ff @(posedge clk) begin
        if (rst || i_load) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != c_LAST)) begin
            r_cnt <= r_cnt + c_W'(1);
        end
    end

    assign o_expire = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/fetch_sched.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sched
//  Description : Instruction fetch scheduler. Issues one outstanding fetch
//                request at a time, advances the PC from responses, handles
//                redirects/flushes, stale-response dropping and timeouts.
//                Optional build macro FETCH_SCHED_PERF_EN adds saturating
//                fetch/stall performance counters.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_sched
    import iq_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          TABLESIZE    = 10,
    parameter int          RESP_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_redirectValid_1,
    input  logic [31:0] i_redirectPC_32,
    input  logic [7:0]  i_room_8,
    output logic        o_fetchReqValid_1,
    input  logic        i_fetchReqReady_1,
    output logic [31:0] o_fetchPC_32,
    input  logic        i_fetchRespValid_1,
    input  logic [7:0]  i_cutPosition_8,
    input  logic        i_predTaken_1,
    input  logic [31:0] i_predictAddr_32,
    output logic        o_queueDrive_1,
    output logic        o_flush_1,
`ifdef FETCH_SCHED_PERF_EN
    output logic [31:0] o_fetchCnt_32,
    output logic [31:0] o_stallCnt_32,
`endif
    output logic [1:0]  o_state_2
);

    localparam logic [7:0] c_TABLE    = 8'(TABLESIZE);
    localparam logic [7:0] c_CUT_NONE = 8'hFF;

    fetch_state_t r_state, w_state_nxt;
    logic [31:0]  r_pc, w_pc_nxt;
    logic         r_drop, w_drop_nxt;

    logic         w_room_ok;
    logic         w_cut_valid;
    logic         w_push;
    logic [31:0]  w_seq_pc;
    logic         w_tmo_load;
    logic         w_tmo_enable;
    logic         w_tmo_expire;

    assign w_room_ok   = (i_room_8 >= c_TABLE);
    assign w_cut_valid = (i_cutPosition_8 != c_CUT_NONE);
    assign w_seq_pc    = r_pc + (({24'd0, i_cutPosition_8} + 32'd1) << 2);

    // A redirect in the same cycle as a response wins, so no push then.
    assign w_push = !rst && (r_state == ST_WAIT) && i_fetchRespValid_1
                    && !i_redirectValid_1 && w_cut_valid;

    // The counter only runs while genuinely waiting; anything else clears it.
    assign w_tmo_enable = (r_state == ST_WAIT) && !i_fetchRespValid_1 && !i_redirectValid_1;
    assign w_tmo_load   = !w_tmo_enable || w_tmo_expire;

    fetch_timeout #(
        .LIMIT    (RESP_TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_tmo_load),
        .i_enable (w_tmo_enable),
        .o_expire (w_tmo_expire)
    );

    // Next-state, next-PC and drop-flag decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_drop_nxt  = r_drop;

        case (r_state)
            ST_IDLE: begin
                // A pending stale response must drain before a new request.
                if (!r_drop && w_room_ok) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_fetchReqReady_1) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_fetchRespValid_1) begin
                    w_state_nxt = ST_IDLE;
                    if (w_cut_valid) begin
                        w_pc_nxt = i_predTaken_1 ? i_predictAddr_32 : w_seq_pc;
                    end
                end else if (w_tmo_expire) begin
                    w_state_nxt = ST_REQ;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Outside WAIT any response belongs to a request abandoned by a redirect.
        if (r_drop && i_fetchRespValid_1) begin
            w_drop_nxt = 1'b0;
        end

        if (i_redirectValid_1) begin
            w_pc_nxt    = i_redirectPC_32;
            w_state_nxt = ST_FLUSH;
            // A request still in flight will answer later and must be discarded.
            if (((r_state == ST_WAIT) && !i_fetchRespValid_1) ||
                ((r_state == ST_REQ) && i_fetchReqReady_1)) begin
                w_drop_nxt = 1'b1;
            end
        end
    end

    // State, PC and drop-flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_drop  <= w_drop_nxt;
        end
    end

    assign o_fetchReqValid_1 = !rst && (r_state == ST_REQ);
    assign o_fetchPC_32      = r_pc;
    assign o_queueDrive_1    = w_push;
    assign o_flush_1         = rst || (r_state == ST_FLUSH);
    assign o_state_2         = r_state;

`ifdef FETCH_SCHED_PERF_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    // Saturating counters for pushed responses and room-starved idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_push && (r_fetch_cnt != 32'hFFFF_FFFF)) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if ((r_state == ST_IDLE) && !w_room_ok && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign o_fetchCnt_32 = r_fetch_cnt;
    assign o_stallCnt_32 = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_sched
//  Description : Self-checking bench for fetch_sched: directed scenarios plus
//                randomized fetch responses against a PC reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_sched;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
    localparam int          c_TMO      = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [7:0]  room;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] fetch_pc;
    logic        resp_valid;
    logic [7:0]  cut;
    logic        pred_taken;
    logic [31:0] pred_addr;
    logic        queue_drive;
    logic        flush;
    logic [1:0]  state;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_pc;

    always #5 clk = ~clk;

    fetch_sched #(
        .RESET_PC           (c_RESET_PC),
        .TABLESIZE          (10),
        .RESP_TIMEOUT       (c_TMO)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .i_redirectValid_1  (redirect_valid),
        .i_redirectPC_32    (redirect_pc),
        .i_room_8           (room),
        .o_fetchReqValid_1  (req_valid),
        .i_fetchReqReady_1  (req_ready),
        .o_fetchPC_32       (fetch_pc),
        .i_fetchRespValid_1 (resp_valid),
        .i_cutPosition_8    (cut),
        .i_predTaken_1      (pred_taken),
        .i_predictAddr_32   (pred_addr),
        .o_queueDrive_1     (queue_drive),
        .o_flush_1          (flush),
        .o_state_2          (state)
    );

    // Reference rule for the PC that follows a response.
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [7:0] c,
                                             input logic tk, input logic [31:0] addr);
        longint unsigned sum;
        if (c == 8'hFF) return pc;
        if (tk) return addr;
        sum = longint'(pc) + 4 * (longint'(c) + 1);
        return sum[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (!req_valid && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_reqv"}, {31'd0, req_valid}, 32'd1);
    endtask

    // One complete request/response exchange, expected PC from the model.
    task automatic fetch(input string tag, input logic [7:0] c, input logic tk,
                         input logic [31:0] addr, input int dly);
        wait_req(tag);
        chk({tag, "_pc"}, fetch_pc, m_pc);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        chk({tag, "_wait"}, {30'd0, state}, 32'd2);
        repeat (dly) tick();
        resp_valid = 1'b1;
        cut        = c;
        pred_taken = tk;
        pred_addr  = addr;
        #1;
        chk({tag, "_push"}, {31'd0, queue_drive}, {31'd0, (c != 8'hFF)});
        tick();
        m_pc       = ref_next(m_pc, c, tk, addr);
        resp_valid = 1'b0;
        pred_taken = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        room           = 8'd10;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        cut            = 8'd0;
        pred_taken     = 1'b0;
        pred_addr      = 32'd0;
        m_pc           = c_RESET_PC;

        // Reset values
        repeat (3) tick();
        chk("rst_flush", {31'd0, flush}, 32'd1);
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_reqv",  {31'd0, req_valid}, 32'd0);
        chk("rst_push",  {31'd0, queue_drive}, 32'd0);
        chk("rst_pc",    fetch_pc, c_RESET_PC);
        rst = 1'b0;
        #1;
        chk("rel_flush", {31'd0, flush}, 32'd0);
        tick();
        chk("c1_reqv", {31'd0, req_valid}, 32'd1);
        chk("c1_pc", fetch_pc, 32'h0);

        // Sequential advance and predicted-taken jump
        fetch("seq3", 8'd3, 1'b0, 32'd0, 2);
        chk("model_0x10", m_pc, 32'h10);
        fetch("taken", 8'd5, 1'b1, 32'h400, 1);
        fetch("at400", 8'd0, 1'b0, 32'd0, 0);

        // Redirect while requesting, then wrap-around arithmetic
        wait_req("redq");
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        chk("redq_state", {30'd0, state}, 32'd3);
        chk("redq_flush", {31'd0, flush}, 32'd1);
        m_pc = 32'hFFFF_FFF8;
        tick();
        chk("redq_flush1", {31'd0, flush}, 32'd0);
        fetch("wrap", 8'd9, 1'b0, 32'd0, 3);
        chk("model_wrap", m_pc, 32'h20);
        fetch("after_wrap", 8'd1, 1'b0, 32'd0, 0);

        // Insufficient room holds the scheduler in IDLE
        wait_req("room");
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        room       = 8'd6;
        resp_valid = 1'b1;
        cut        = 8'd1;
        #1;
        chk("room_push", {31'd0, queue_drive}, 32'd1);
        tick();
        resp_valid = 1'b0;
        m_pc = ref_next(m_pc, 8'd1, 1'b0, 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("room_noreq", {31'd0, req_valid}, 32'd0);
            tick();
        end
        chk("room_idle", {30'd0, state}, 32'd0);
        room = 8'd10;
        fetch("room_ok", 8'd2, 1'b0, 32'd0, 0);

        // Redirect during WAIT: flush, drop the stale response, refetch at target
        wait_req("redw");
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h800;
        #1;
        chk("redw_nopush", {31'd0, queue_drive}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        chk("redw_flush", {31'd0, flush}, 32'd1);
        tick();
        chk("redw_flush_once", {31'd0, flush}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("redw_hold", {31'd0, req_valid}, 32'd0);
            tick();
        end
        resp_valid = 1'b1;
        cut        = 8'd2;
        #1;
        chk("stale_nopush", {31'd0, queue_drive}, 32'd0);
        tick();
        resp_valid = 1'b0;
        m_pc = 32'h800;
        fetch("at800", 8'd4, 1'b0, 32'd0, 1);

        // Back-to-back redirects keep FLUSH and take the latest target
        wait_req("redf");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        chk("redf_state", {30'd0, state}, 32'd3);
        tick();
        chk("redf_idle", {30'd0, state}, 32'd0);
        m_pc = 32'h200;

        // Timeout re-issues the same PC after RESP_TIMEOUT waiting cycles
        begin
            int n;
            wait_req("tmo");
            chk("tmo_pc", fetch_pc, m_pc);
            req_ready = 1'b1;
            tick();
            req_ready = 1'b0;
            n = 0;
            while (!req_valid && n < 200) begin
                tick();
                n++;
            end
            chk("tmo_cycles", n, c_TMO);
            chk("tmo_same_pc", fetch_pc, m_pc);
        end

        // No valid instruction: no push, same PC refetched
        fetch("cutff", 8'hFF, 1'b0, 32'd0, 2);
        fetch("refetch", 8'd0, 1'b1, 32'h1230, 0);

        // Randomized responses
        for (int i = 0; i < 20; i++) begin
            logic [7:0]  rc;
            logic        rt;
            logic [31:0] ra;
            rc = ($urandom_range(0, 6) == 0) ? 8'hFF : 8'($urandom_range(0, 9));
            rt = ($urandom_range(0, 3) == 0);
            ra = $urandom & 32'hFFFF_FFFC;
            fetch("rand", rc, rt, ra, int'($urandom_range(0, 4)));
        end

        // Reset in the middle of a request abandons it
        wait_req("rmid");
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        rst        = 1'b1;
        resp_valid = 1'b1;
        cut        = 8'd1;
        #1;
        chk("rmid_flush", {31'd0, flush}, 32'd1);
        chk("rmid_nopush", {31'd0, queue_drive}, 32'd0);
        tick();
        tick();
        chk("rmid_state", {30'd0, state}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rmid_post_nopush", {31'd0, queue_drive}, 32'd0);
        tick();
        resp_valid = 1'b0;
        m_pc = c_RESET_PC;
        wait_req("rmid_req");
        chk("rmid_pc", fetch_pc, m_pc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_sched.md
FETCH_SCHED -- requirements
Module: fetch_sched

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter TABLESIZE, default 10, instructions per fetch response (aligned table entries).
REQ-003 Parameter RESP_TIMEOUT, default 64, cycles in WAIT before a request is re-issued.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 i_redirectValid_1  in  1  backend/predictor redirect pulse.
REQ-007 i_redirectPC_32  in  32  redirect target.
REQ-008 i_room_8  in  8  free instruction slots reported by the instruction queue.
REQ-009 o_fetchReqValid_1  out  1  fetch request to I-side.
REQ-010 i_fetchReqReady_1  in  1  I-side accepts request.
REQ-011 o_fetchPC_32  out  32  address of current request.
REQ-012 i_fetchRespValid_1  in  1  response for the outstanding request.
REQ-013 i_cutPosition_8  in  8  index of last valid instruction in response; 8'hFF = none valid.
REQ-014 i_predTaken_1  in  1  response contains a predicted-taken jump.
REQ-015 i_predictAddr_32  in  32  predicted target when i_predTaken_1.
REQ-016 o_queueDrive_1  out  1  one-cycle push strobe to the instruction queue.
REQ-017 o_flush_1  out  1  one-cycle queue flush strobe.
REQ-018 o_state_2  out  2  current FSM state, for debug.

Function
REQ-019 FSM states SHALL be IDLE=0, REQ=1, WAIT=2, FLUSH=3.
REQ-020 IDLE SHALL go to REQ when i_room_8 >= TABLESIZE, otherwise stay.
REQ-021 REQ SHALL drive o_fetchReqValid_1=1 with o_fetchPC_32 held stable until i_fetchReqReady_1; the handshake cycle SHALL move to WAIT.
REQ-022 At most one request SHALL be outstanding.
REQ-023 In WAIT, on i_fetchRespValid_1: o_queueDrive_1=1 the same cycle (combinational from the valid); the next PC SHALL be i_predictAddr_32 if i_predTaken_1, else PC + 4*(i_cutPosition_8+1); the FSM SHALL go to IDLE.
REQ-024 A response with i_cutPosition_8=8'hFF SHALL NOT assert o_queueDrive_1, SHALL NOT advance PC, and SHALL go to IDLE (refetch same PC).
REQ-025 PC arithmetic SHALL be 32-bit modulo 2^32; wrap-around is not an error.
REQ-026 A timeout counter SHALL count WAIT cycles; reaching RESP_TIMEOUT-1 without a response SHALL return to REQ with the same PC, counter cleared.
REQ-027 i_redirectValid_1 in any state SHALL load the PC with i_redirectPC_32 and go to FLUSH the next cycle; redirect overrides a simultaneous response (no o_queueDrive_1 that cycle).
REQ-028 FLUSH SHALL assert o_flush_1 for exactly one cycle, then go to IDLE.
REQ-029 A redirect issued while WAIT SHALL set a drop flag; the first later i_fetchRespValid_1 SHALL be discarded (no push, no PC change) and clear the flag; no new request SHALL be issued while the flag is set.
REQ-030 A redirect during FLUSH SHALL reload the PC and remain in FLUSH one more cycle.

Reset
REQ-031 On rst: state=IDLE, PC=RESET_PC, drop flag=0, timeout counter=0, o_fetchReqValid_1=0, o_queueDrive_1=0, o_flush_1=1 for the reset cycles, o_state_2=0.
REQ-032 Reset asserted mid-request SHALL abandon the request; a response arriving in the first cycle after reset release SHALL be ignored.

Configuration
REQ-033 Macro FETCH_SCHED_PERF_EN: when defined, add outputs o_fetchCnt_32 (accepted responses that pushed) and o_stallCnt_32 (cycles in IDLE with room < TABLESIZE), saturating, cleared by rst; when undefined, these ports and counters SHALL not exist.

Structure
REQ-034 Shared package iq_pkg SHALL hold ISSUEWIDTH=4, BUFFERSIZE=10, TABLESIZE=10, the NOP encoding 32'h0000_0013, and the FSM state enumeration.
REQ-035 The timeout counter SHALL be a sub-module fetch_timeout (load, enable, expire).

Verification
REQ-036 Reset, room=10, ready=1 -> cycle1 req PC=0; response cut=3, no taken -> push, next req PC=0x10.
REQ-037 Response taken, predictAddr=0x400 -> next req PC=0x400; cut=9 at PC=0xFFFF_FFF8 no taken -> PC wraps to 0x0000_0020.
REQ-038 room=6 after push -> no request until room>=10; with PERF_EN, stallCnt increments each waiting cycle.
REQ-039 Redirect to 0x800 during WAIT -> flush one cycle, stale response dropped without push, next req PC=0x800.
REQ-040 No response for RESP_TIMEOUT cycles -> request re-issued at same PC; cut=8'hFF response -> no push, same PC refetched.
